snitch_icache_refill_writer: RTL and testbench

SNITCH_ICACHE_REFILL_WRITER -- requirements
Module: snitch_icache_refill_writer

---
 rtl/snitch_icache_refill_writer.sv | 200 ++++++++++++++++++++
 tb/tb_snitch_icache_refill_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_refill_writer.sv
// Miss handler for the instruction cache: forwards hits to the fetch side, and
// refills one missing line at a time into the tag/data arrays.

package snitch_icache_pkg;
    typedef struct packed {
        int unsigned FETCH_AW;
        int unsigned ID_WIDTH;
        int unsigned LINE_WIDTH;
        int unsigned LINE_ALIGN;
        int unsigned COUNT_ALIGN;
        int unsigned SET_ALIGN;
        int unsigned TAG_WIDTH;
        int unsigned WAY_COUNT;
    } config_t;
endpackage

module snitch_icache_refill_writer
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = '0,
    // A zero field falls back to the reference geometry so the block stays elaboratable.
    localparam int unsigned FETCH_AW    = (CFG.FETCH_AW    != 0) ? CFG.FETCH_AW    : 32,
    localparam int unsigned ID_WIDTH    = (CFG.ID_WIDTH    != 0) ? CFG.ID_WIDTH    : 4,
    localparam int unsigned LINE_WIDTH  = (CFG.LINE_WIDTH  != 0) ? CFG.LINE_WIDTH  : 128,
    localparam int unsigned LINE_ALIGN  = (CFG.LINE_ALIGN  != 0) ? CFG.LINE_ALIGN  : 4,
    localparam int unsigned COUNT_ALIGN = (CFG.COUNT_ALIGN != 0) ? CFG.COUNT_ALIGN : 5,
    localparam int unsigned SET_ALIGN   = (CFG.SET_ALIGN   != 0) ? CFG.SET_ALIGN   : 2,
    localparam int unsigned TAG_WIDTH   = (CFG.TAG_WIDTH   != 0) ? CFG.TAG_WIDTH
                                          : FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
    localparam int unsigned WAY_COUNT   = (CFG.WAY_COUNT   != 0) ? CFG.WAY_COUNT   : 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   flush_valid_i,
    output logic                   flush_ready_o,

    input  logic [FETCH_AW-1:0]    in_addr_i,
    input  logic [ID_WIDTH-1:0]    in_id_i,
    input  logic [SET_ALIGN-1:0]   in_set_i,
    input  logic                   in_hit_i,
    input  logic [LINE_WIDTH-1:0]  in_data_i,
    input  logic                   in_error_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,

    output logic [FETCH_AW-1:0]    refill_addr_o,
    output logic                   refill_req_valid_o,
    input  logic                   refill_req_ready_i,
    input  logic [LINE_WIDTH-1:0]  refill_data_i,
    input  logic                   refill_error_i,
    input  logic                   refill_rsp_valid_i,
    output logic                   refill_rsp_ready_o,

    output logic [COUNT_ALIGN-1:0] write_addr_o,
    output logic [SET_ALIGN-1:0]   write_set_o,
    output logic [LINE_WIDTH-1:0]  write_data_o,
    output logic [TAG_WIDTH-1:0]   write_tag_o,
    output logic                   write_error_o,
    output logic                   write_valid_o,
    input  logic                   write_ready_i,

    output logic [LINE_WIDTH-1:0]  rsp_data_o,
    output logic [ID_WIDTH-1:0]    rsp_id_o,
    output logic                   rsp_error_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,

    output logic [15:0]            miss_count_o
);

    // Every channel is valid/ready: a transfer happens on a rising edge where both
    // are high; a raised valid and its payload stay put until that edge.

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        RESP
    } state_e;

    localparam logic [SET_ALIGN-1:0] LAST_WAY = SET_ALIGN'(WAY_COUNT - 1);

    state_e                             state_q, state_d;
    logic [FETCH_AW-LINE_ALIGN-1:0]     line_q;
    logic [ID_WIDTH-1:0]                id_q;
    logic [LINE_WIDTH-1:0]              data_q;
    logic                               error_q;
    logic [SET_ALIGN-1:0]               victim_q;
    logic [15:0]                        miss_cnt_q;

    logic accept_miss;
    logic take_refill;
    logic write_hs;
    logic flush_hs;

    // The hit way and intra-line offset are not needed to refill a line.
    logic unused_in;
    assign unused_in = ^{in_set_i, in_addr_i[LINE_ALIGN-1:0]};

    always_comb begin
        state_d            = state_q;
        accept_miss        = 1'b0;
        take_refill        = 1'b0;
        write_hs           = 1'b0;
        flush_hs           = 1'b0;
        flush_ready_o      = 1'b0;
        in_ready_o         = 1'b0;
        refill_req_valid_o = 1'b0;
        refill_rsp_ready_o = 1'b0;
        write_valid_o      = 1'b0;
        rsp_valid_o        = 1'b0;
        rsp_data_o         = data_q;
        rsp_id_o           = id_q;
        rsp_error_o        = 1'b0;

        unique case (state_q)
            IDLE: begin
                flush_ready_o = 1'b1;
                if (flush_valid_i) begin
                    // Flush wins; the pending lookup is neither answered nor consumed.
                    flush_hs = 1'b1;
                end else if (in_valid_i && in_hit_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_data_o  = in_data_i;
                    rsp_id_o    = in_id_i;
                    rsp_error_o = in_error_i;
                    in_ready_o  = rsp_ready_i;
                end else if (in_valid_i) begin
                    in_ready_o  = 1'b1;
                    accept_miss = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                refill_req_valid_o = 1'b1;
                if (refill_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                refill_rsp_ready_o = 1'b1;
                if (refill_rsp_valid_i) begin
                    take_refill = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                write_valid_o = 1'b1;
                if (write_ready_i) begin
                    write_hs = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_error_o = error_q;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            line_q     <= '0;
            id_q       <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
            victim_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_miss) begin
                line_q <= in_addr_i[FETCH_AW-1:LINE_ALIGN];
                id_q   <= in_id_i;
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (take_refill) begin
                data_q  <= refill_data_i;
                error_q <= refill_error_i;
            end
            // Round-robin replacement; a flush restarts from way 0.
            if (flush_hs) begin
                victim_q <= '0;
            end else if (write_hs) begin
                victim_q <= (victim_q == LAST_WAY) ? '0 : victim_q + SET_ALIGN'(1);
            end
        end
    end

    assign refill_addr_o = {line_q, {LINE_ALIGN{1'b0}}};
    assign write_addr_o  = line_q[COUNT_ALIGN-1:0];
    assign write_tag_o   = TAG_WIDTH'(line_q >> COUNT_ALIGN);
    assign write_set_o   = victim_q;
    assign write_data_o  = data_q;
    assign write_error_o = error_q;
    assign miss_count_o  = miss_cnt_q;

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Directed bench for the refill writer: hits, misses, victim rotation, flush,
// backpressure, refill errors and reset in mid-miss, with a response scoreboard.

module tb_snitch_icache_refill_writer;
    import snitch_icache_pkg::*;

    localparam config_t CFG = '{FETCH_AW: 32, ID_WIDTH: 4, LINE_WIDTH: 128, LINE_ALIGN: 4,
                                COUNT_ALIGN: 5, SET_ALIGN: 2, TAG_WIDTH: 23, WAY_COUNT: 4};
    localparam int RW = 128 + 4 + 1;

    logic         clk;
    logic         rst_n;
    logic         flush_valid;
    logic         flush_ready;
    logic [31:0]  in_addr;
    logic [3:0]   in_id;
    logic [1:0]   in_set;
    logic         in_hit;
    logic [127:0] in_data;
    logic         in_error;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  refill_addr;
    logic         refill_req_valid;
    logic         refill_req_ready;
    logic [127:0] refill_data;
    logic         refill_error;
    logic         refill_rsp_valid;
    logic         refill_rsp_ready;
    logic [4:0]   write_addr;
    logic [1:0]   write_set;
    logic [127:0] write_data;
    logic [22:0]  write_tag;
    logic         write_error;
    logic         write_valid;
    logic         write_ready;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_id;
    logic         rsp_error;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  miss_count;

    snitch_icache_refill_writer #(.CFG(CFG)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_valid_i      (flush_valid),
        .flush_ready_o      (flush_ready),
        .in_addr_i          (in_addr),
        .in_id_i            (in_id),
        .in_set_i           (in_set),
        .in_hit_i           (in_hit),
        .in_data_i          (in_data),
        .in_error_i         (in_error),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .refill_addr_o      (refill_addr),
        .refill_req_valid_o (refill_req_valid),
        .refill_req_ready_i (refill_req_ready),
        .refill_data_i      (refill_data),
        .refill_error_i     (refill_error),
        .refill_rsp_valid_i (refill_rsp_valid),
        .refill_rsp_ready_o (refill_rsp_ready),
        .write_addr_o       (write_addr),
        .write_set_o        (write_set),
        .write_data_o       (write_data),
        .write_tag_o        (write_tag),
        .write_error_o      (write_error),
        .write_valid_o      (write_valid),
        .write_ready_i      (write_ready),
        .rsp_data_o         (rsp_data),
        .rsp_id_o           (rsp_id),
        .rsp_error_o        (rsp_error),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .miss_count_o       (miss_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [RW-1:0] exp_q[$];
    int total;
    int bad;
    int vict;
    int mcnt;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic sb_pop();
        logic [RW-1:0] e;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e[132:5]);
            chk("rsp_id", rsp_id, e[4:1]);
            chk("rsp_error", rsp_error, e[0]);
        end
    endtask

    task automatic do_hit(input logic [3:0] id, input logic err);
        logic [127:0] d;
        d = rand_line();
        @(negedge clk);
        in_valid = 1'b1; in_hit = 1'b1; in_id = id; in_data = d; in_error = err;
        in_addr = $urandom; in_set = 2'($urandom_range(0, 3)); rsp_ready = 1'b1;
        exp_q.push_back({d, id, err});
        #1;
        chk("hit_rsp_valid", rsp_valid, 1);
        chk("hit_in_ready", in_ready, 1);
        sb_pop();
        chk("hit_no_refill", refill_req_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_hit = 1'b0; rsp_ready = 1'b0;
        chk("hit_stays_idle", flush_ready, 1);
        chk("hit_no_refill_next", refill_req_valid, 0);
    endtask

    // abort: 0 = full miss, 1 = reset while in WAIT, 2 = reset while in WRITE
    task automatic do_miss(input logic [31:0] addr, input logic [3:0] id, input logic err,
                           input int req_stall, input int wr_stall, input int abort,
                           input bit flush_in_wait);
        logic [127:0] d;
        int n;
        int hi;
        d = rand_line();
        @(negedge clk);
        in_valid = 1'b1; in_hit = 1'b0; in_addr = addr; in_id = id; in_data = rand_line();
        #1;
        chk("miss_in_ready", in_ready, 1);
        chk("miss_no_rsp", rsp_valid, 0);
        exp_q.push_back({d, id, err});
        if (mcnt < 65535) mcnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;

        for (int i = 0; i <= req_stall; i++) begin
            chk("req_valid", refill_req_valid, 1);
            chk("req_addr", refill_addr, {addr[31:4], 4'h0});
            chk("req_flush_ready", flush_ready, 0);
            if (i == req_stall) refill_req_ready = 1'b1;
            @(posedge clk); #1;
        end
        refill_req_ready = 1'b0;
        chk("miss_count", miss_count, mcnt);

        chk("wait_rsp_ready", refill_rsp_ready, 1);
        chk("wait_no_req", refill_req_valid, 0);
        if (abort == 1) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk("rst_wait_rsp_ready", refill_rsp_ready, 0);
            chk("rst_wait_idle", flush_ready, 1);
            chk("rst_wait_miss_count", miss_count, 0);
            void'(exp_q.pop_back());
            vict = 0; mcnt = 0;
            return;
        end
        if (flush_in_wait) begin
            flush_valid = 1'b1;
            #1;
            chk("wait_flush_ready", flush_ready, 0);
        end
        refill_rsp_valid = 1'b1; refill_data = d; refill_error = err;
        @(posedge clk); #1;
        refill_rsp_valid = 1'b0; refill_data = rand_line(); refill_error = ~err;

        n = 0;
        while (!write_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("write_latency", n, 0);
        if (abort == 2) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk("rst_write_valid", write_valid, 0);
            chk("rst_write_idle", flush_ready, 1);
            chk("rst_write_miss_count", miss_count, 0);
            void'(exp_q.pop_back());
            vict = 0; mcnt = 0;
            return;
        end
        hi = 0;
        for (int i = 0; i <= wr_stall; i++) begin
            if (write_valid) hi++;
            chk("write_addr", write_addr, addr[8:4]);
            chk("write_tag", write_tag, addr[31:9]);
            chk("write_set", write_set, vict);
            chk("write_data", write_data, d);
            chk("write_error", write_error, err);
            chk("write_no_rsp", rsp_valid, 0);
            chk("write_flush_ready", flush_ready, 0);
            if (i == wr_stall) write_ready = 1'b1;
            @(posedge clk); #1;
        end
        write_ready = 1'b0;
        chk("write_valid_cycles", hi, wr_stall + 1);
        vict = (vict + 1) % 4;

        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_latency", n, 0);
        chk("resp_flush_ready", flush_ready, 0);
        if (rsp_valid) sb_pop();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("back_to_idle", flush_ready, 1);
        chk("resp_dropped", rsp_valid, 0);
        if (flush_in_wait) begin
            @(posedge clk); #1;
            flush_valid = 1'b0;
            vict = 0;
        end
    endtask

    task automatic do_flush(input bit with_miss);
        @(negedge clk);
        flush_valid = 1'b1;
        if (with_miss) begin
            in_valid = 1'b1; in_hit = 1'b0; in_addr = $urandom; in_id = 4'($urandom_range(0, 15));
        end
        #1;
        chk("flush_ready", flush_ready, 1);
        chk("flush_blocks_in", in_ready, 0);
        @(posedge clk); #1;
        flush_valid = 1'b0; in_valid = 1'b0;
        vict = 0;
        chk("flush_no_req", refill_req_valid, 0);
        chk("flush_idle", flush_ready, 1);
        chk("flush_miss_count", miss_count, mcnt);
    endtask

    // Directed sequence
    initial begin
        total = 0; bad = 0; vict = 0; mcnt = 0;
        rst_n = 1'b0; flush_valid = 1'b0;
        in_addr = '0; in_id = '0; in_set = '0; in_hit = 1'b0; in_data = '0;
        in_error = 1'b0; in_valid = 1'b0;
        refill_req_ready = 1'b0; refill_data = '0; refill_error = 1'b0; refill_rsp_valid = 1'b0;
        write_ready = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_flush_ready", flush_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_valid", refill_req_valid, 0);
        chk("rst_rsp_ready", refill_rsp_ready, 0);
        chk("rst_write_valid", write_valid, 0);
        chk("rst_miss_count", miss_count, 0);

        do_hit(4'd3, 1'b0);

        do_miss(32'h0000_1234, 4'd5, 1'b0, 0, 0, 0, 1'b0);
        do_miss($urandom, 4'd6, 1'b0, $urandom_range(0, 3), 0, 0, 1'b0);
        do_miss($urandom, 4'd7, 1'b1, $urandom_range(0, 3), 5, 0, 1'b0);
        do_miss($urandom, 4'd8, 1'b0, 0, $urandom_range(0, 3), 0, 1'b0);
        do_miss($urandom, 4'd9, 1'b0, 1, 0, 0, 1'b0);
        chk("miss_count_five", miss_count, 5);

        do_flush(1'b0);
        do_miss($urandom, 4'd1, 1'b0, 0, 0, 0, 1'b0);
        do_miss($urandom, 4'd2, 1'b0, 0, 0, 0, 1'b0);
        do_flush(1'b1);
        do_miss($urandom, 4'd3, 1'b0, 0, 0, 0, 1'b0);

        do_miss($urandom, 4'd4, 1'b1, 0, 1, 0, 1'b1);
        do_miss($urandom, 4'd10, 1'b0, 0, 0, 0, 1'b0);

        do_miss($urandom, 4'd11, 1'b0, 0, 0, 1, 1'b0);
        do_miss($urandom, 4'd12, 1'b0, 2, 0, 2, 1'b0);
        do_miss($urandom, 4'd13, 1'b0, 0, 0, 0, 1'b0);
        chk("miss_count_after_reset", miss_count, 1);

        do_hit(4'd14, 1'b1);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
